seq_mul_hs: RTL and testbench

//  Parametrised iterative (shift-add) multiplier, successor to the single-cycle 8x8 multiplier.

---
 rtl/seq_mul_hs_if.sv | 25 ++
 rtl/seq_mul_hs.sv | 113 +++++++++++
 tb/tb_seq_mul_hs.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mul_hs_if.sv
// Request/result handshake bundle for the iterative multiplier.
// The master side drives operands and result acceptance; the slave side is the multiplier.
interface seq_mul_hs_if #(
  parameter int WIDTH = 8
);
  logic                 en;
  logic                 rdy;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 sgn;
  logic [2*WIDTH-1:0]   out;
  logic                 ack;
  logic                 ack_rdy;
  logic                 busy;

  modport master (
    output en, a, b, sgn, ack_rdy,
    input  rdy, out, ack, busy
  );

  modport slave (
    input  en, a, b, sgn, ack_rdy,
    output rdy, out, ack, busy
  );
endinterface

// File: rtl/seq_mul_hs.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per cycle on magnitudes,
// with the sign reapplied once at the end; the result is held until the consumer takes it.
module seq_mul_hs #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  seq_mul_hs_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_param
      $error("seq_mul_hs: STEP must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic [PW-1:0]   out_q;
  logic            ack_q;
  logic            busy_q;
  logic            rdy_q;

  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [PW-1:0]    pp_d;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    pp_terms [STEP];

  // -2^(W-1) negates to itself, which read unsigned is exactly its magnitude.
  assign mag_a_d = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b_d = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_pp
      assign pp_terms[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_d = '0;
    for (int k = 0; k < STEP; k++) begin
      pp_d = pp_d + pp_terms[k];
    end
    acc_d = acc_q + pp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.en) begin
            mcand_q  <= PW'(mag_a_d);
            mplier_q <= mag_b_d;
            neg_q    <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            out_q   <= neg_q ? -acc_d : acc_d;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.ack_rdy) begin
            ack_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rdy  = rdy_q;
  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;
  assign bus.out  = out_q;
endmodule

// File: tb/tb_seq_mul_hs.sv
// Bench for seq_mul_hs: a STEP=1 and a STEP=2 instance run against a timing/arithmetic model,
// plus directed transactions with literal expectations.
module tb_seq_mul_hs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] en_s      = '0;
  logic [1:0] sgn_s     = '0;
  logic [1:0] ack_rdy_s = '0;
  logic [7:0] a_s [2]   = '{8'd0, 8'd0};
  logic [7:0] b_s [2]   = '{8'd0, 8'd0};
  logic [1:0] rdy_s;
  logic [1:0] ack_s;
  logic [1:0] busy_s;
  logic [15:0] out_s [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      seq_mul_hs_if #(.WIDTH(8)) bus ();
      assign bus.en      = en_s[gi];
      assign bus.a       = a_s[gi];
      assign bus.b       = b_s[gi];
      assign bus.sgn     = sgn_s[gi];
      assign bus.ack_rdy = ack_rdy_s[gi];
      assign rdy_s[gi]   = bus.rdy;
      assign ack_s[gi]   = bus.ack;
      assign busy_s[gi]  = bus.busy;
      assign out_s[gi]   = bus.out;
      seq_mul_hs #(.WIDTH(8), .STEP(gi + 1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  // Reference: product by plain arithmetic, ack appearing N edges after acceptance.
  function automatic logic [15:0] product(input logic [7:0] x, input logic [7:0] y, input logic s);
    int xi;
    int yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  logic [1:0]  m_rdy  = 2'b11;
  logic [1:0]  m_busy = 2'b00;
  logic [1:0]  m_ack  = 2'b00;
  logic [15:0] m_out  [2] = '{16'd0, 16'd0};
  logic [15:0] m_prod [2] = '{16'd0, 16'd0};
  int          m_left [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_rdy[i]  <= 1'b1;
        m_busy[i] <= 1'b0;
        m_ack[i]  <= 1'b0;
        m_out[i]  <= '0;
        m_left[i] <= 0;
      end else if (m_rdy[i] && en_s[i]) begin
        m_prod[i] <= product(a_s[i], b_s[i], sgn_s[i]);
        m_left[i] <= 8 / (i + 1);
        m_rdy[i]  <= 1'b0;
        m_busy[i] <= 1'b1;
      end else if (m_busy[i]) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_ack[i]  <= 1'b1;
          m_out[i]  <= m_prod[i];
        end
      end else if (m_ack[i] && ack_rdy_s[i]) begin
        m_ack[i] <= 1'b0;
        m_rdy[i] <= 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, got, exp);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("rdy", i, 16'(rdy_s[i]), 16'(m_rdy[i]));
      chk("busy", i, 16'(busy_s[i]), 16'(m_busy[i]));
      chk("ack", i, 16'(ack_s[i]), 16'(m_ack[i]));
      chk("out", i, out_s[i], m_out[i]);
    end
  endtask

  // Advance one edge, then compare everything at the following falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic run_op(input int i, input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [15:0] exp, input int exp_lat, input int hold);
    int lat;
    chk("rdy_before", i, 16'(rdy_s[i]), 16'd1);
    en_s[i] = 1'b1; a_s[i] = x; b_s[i] = y; sgn_s[i] = s; ack_rdy_s[i] = 1'b0;
    tick();
    en_s[i] = 1'b0;
    a_s[i] = 8'($urandom); b_s[i] = 8'($urandom); sgn_s[i] = 1'($urandom);
    lat = 0;
    while (!ack_s[i] && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", i, 16'(lat), 16'(exp_lat));
    chk("result", i, out_s[i], exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("ack_hold", i, 16'(ack_s[i]), 16'd1);
      chk("out_hold", i, out_s[i], exp);
    end
    ack_rdy_s[i] = 1'b1;
    tick();
    ack_rdy_s[i] = 1'b0;
    chk("ack_drop", i, 16'(ack_s[i]), 16'd0);
    chk("rdy_back", i, 16'(rdy_s[i]), 16'd1);
    $display("op dut%0d %h*%h sgn=%0d -> %h lat=%0d", i, x, y, s, out_s[i], lat);
  endtask

  initial begin
    int last_acc;
    int lat;
    // Pin the reference arithmetic itself.
    chk("model_uu", 0, product(8'hFF, 8'hFF, 1'b0), 16'hFE01);
    chk("model_ss", 0, product(8'h80, 8'h80, 1'b1), 16'h4000);
    chk("model_neg", 0, product(8'hF6, 8'h03, 1'b1), 16'hFFE2);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rdy", i, 16'(rdy_s[i]), 16'd1);
      chk("rst_ack", i, 16'(ack_s[i]), 16'd0);
      chk("rst_busy", i, 16'(busy_s[i]), 16'd0);
      chk("rst_out", i, out_s[i], 16'd0);
    end

    run_op(0, 8'd10, 8'd2, 1'b0, 16'h0014, 8, 3);
    run_op(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 0);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 16'h0001, 8, 0);
    run_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 0);
    run_op(0, 8'hF6, 8'h03, 1'b1, 16'hFFE2, 8, 0);
    run_op(0, 8'h7F, 8'h80, 1'b1, 16'hC080, 8, 0);

    // Requests held high during BUSY/DONE are not taken.
    en_s[0] = 1'b1; a_s[0] = 8'd7; b_s[0] = 8'd6; sgn_s[0] = 1'b0;
    tick();
    a_s[0] = 8'd9; b_s[0] = 8'd9;
    lat = 0;
    while (!ack_s[0] && lat < 40) begin
      chk("rdy_low_busy", 0, 16'(rdy_s[0]), 16'd0);
      tick();
      lat++;
    end
    tick();
    chk("rdy_low_done", 0, 16'(rdy_s[0]), 16'd0);
    chk("no_requeue", 0, out_s[0], 16'h002A);
    en_s[0] = 1'b0; ack_rdy_s[0] = 1'b1;
    tick();
    ack_rdy_s[0] = 1'b0;
    tick();
    chk("second_not_taken", 0, 16'(busy_s[0]), 16'd0);
    chk("out_kept", 0, out_s[0], 16'h002A);
    $display("op dut0 7*6 with en held -> %h", out_s[0]);

    // Reset on the third BUSY cycle discards the product.
    en_s[0] = 1'b1; a_s[0] = 8'd5; b_s[0] = 8'd4; sgn_s[0] = 1'b0;
    tick();
    en_s[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ack", 0, 16'(ack_s[0]), 16'd0);
    chk("midrst_out", 0, out_s[0], 16'd0);
    chk("midrst_busy", 0, 16'(busy_s[0]), 16'd0);
    chk("midrst_rdy", 0, 16'(rdy_s[0]), 16'd1);
    $display("op dut0 5*4 aborted by reset");
    run_op(0, 8'd5, 8'd4, 1'b0, 16'd20, 8, 0);

    // STEP=2 instance.
    run_op(1, 8'd15, 8'd3, 1'b0, 16'd45, 4, 0);
    run_op(1, 8'h80, 8'h80, 1'b1, 16'h4000, 4, 0);

    // Back-to-back with en and ack_rdy tied high: one accept per 6 edges.
    en_s[1] = 1'b1; ack_rdy_s[1] = 1'b1;
    last_acc = -1;
    for (int k = 0; k < 40; k++) begin
      a_s[1] = 8'($urandom); b_s[1] = 8'($urandom); sgn_s[1] = 1'($urandom);
      if (rdy_s[1]) begin
        if (last_acc >= 0) chk("accept_interval", 1, 16'(cyc - last_acc), 16'd6);
        last_acc = cyc;
        $display("accept dut1 cyc %0d a=%h b=%h sgn=%0d", cyc, a_s[1], b_s[1], sgn_s[1]);
      end
      tick();
    end
    en_s[1] = 1'b0;
    repeat (10) tick();
    ack_rdy_s[1] = 1'b0;

    // Random traffic on both instances with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        en_s[i]      = 1'($urandom);
        ack_rdy_s[i] = ($urandom_range(0, 3) != 0);
        a_s[i]       = 8'($urandom);
        b_s[i]       = 8'($urandom);
        sgn_s[i]     = 1'($urandom);
        if (rdy_s[i] && en_s[i])
          $display("accept dut%0d cyc %0d a=%h b=%h sgn=%0d exp=%h", i, cyc, a_s[i], b_s[i],
                   sgn_s[i], product(a_s[i], b_s[i], sgn_s[i]));
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    en_s = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
